// File: rtl/masking_pkg.sv
// Shared types and share-arithmetic helpers for the Boolean-masking datapath.
// WIDTH and NSHARES are fixed here so every file agrees on the share layout.
package masking_pkg;

  localparam int WIDTH   = 8;
  localparam int NSHARES = 8;

  typedef logic [NSHARES-1:0][WIDTH-1:0] share_vec_t;
  typedef logic [NSHARES-2:0][WIDTH-1:0] rand_vec_t;

  // The last share absorbs the secret so the XOR of all shares equals it.
  function automatic share_vec_t create_shares(input logic [WIDTH-1:0] secret,
                                               input rand_vec_t rnd);
    share_vec_t       s;
    logic [WIDTH-1:0] acc;
    acc = secret;
    for (int i = 0; i < NSHARES - 1; i++) begin
      s[i] = rnd[i];
      acc  = acc ^ rnd[i];
    end
    s[NSHARES-1] = acc;
    return s;
  endfunction

  function automatic share_vec_t masked_xor(input share_vec_t a, input share_vec_t b);
    return a ^ b;
  endfunction

  function automatic logic [WIDTH-1:0] recombine_shares(input share_vec_t s);
    logic [WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < NSHARES; i++) begin
      acc = acc ^ s[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/masking_share_gen.sv
// Combinational Boolean share generator: splits one secret into NSHARES shares
// using NSHARES-1 caller-supplied mask bytes.
module masking_share_gen
  import masking_pkg::*;
(
  input  logic [WIDTH-1:0]           secret_i,
  input  logic [WIDTH*(NSHARES-1)-1:0] rand_i,
  output logic [WIDTH*NSHARES-1:0]   shares_o
);

  assign shares_o = create_shares(secret_i, rand_i);

endmodule

// File: rtl/masking_core.sv
// Two-stage masked XOR pipeline: share x and y, XOR share-wise, recombine z.
// Optional MASKING_SHARE_REFRESH_EN adds rand_z to re-mask the result shares.
module masking_core
  import masking_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             x,
  input  logic [WIDTH-1:0]             y,
  input  logic [WIDTH*(NSHARES-1)-1:0] rand_x,
  input  logic [WIDTH*(NSHARES-1)-1:0] rand_y,
`ifdef MASKING_SHARE_REFRESH_EN
  input  logic [WIDTH*(NSHARES-1)-1:0] rand_z,
`endif
  output logic                         out_valid,
  output logic [WIDTH*NSHARES-1:0]     x_shares,
  output logic [WIDTH*NSHARES-1:0]     y_shares,
  output logic [WIDTH*NSHARES-1:0]     z_shares,
  output logic [WIDTH-1:0]             z_out
);

  share_vec_t       x_gen, y_gen;
  share_vec_t       x_sh1_q, y_sh1_q;
  logic             valid1_q;
  share_vec_t       x_sh2_q, y_sh2_q, z_sh_q, z_sh_d;
  logic [WIDTH-1:0] z_out_q, z_out_d;
  logic             out_valid_q;

  masking_share_gen u_x_gen (
    .secret_i (x),
    .rand_i   (rand_x),
    .shares_o (x_gen)
  );

  masking_share_gen u_y_gen (
    .secret_i (y),
    .rand_i   (rand_y),
    .shares_o (y_gen)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_q <= 1'b0;
      x_sh1_q  <= '0;
      y_sh1_q  <= '0;
    end else begin
      valid1_q <= in_valid;
      if (in_valid) begin
        x_sh1_q <= x_gen;
        y_sh1_q <= y_gen;
      end
    end
  end

`ifdef MASKING_SHARE_REFRESH_EN
  rand_vec_t        rz_v;
  logic [WIDTH-1:0] rz_acc;
  assign rz_v = rand_z;
`endif

  // z_out is taken before any refresh; refresh masks XOR to zero anyway.
  always_comb begin
    z_sh_d  = masked_xor(x_sh1_q, y_sh1_q);
    z_out_d = recombine_shares(z_sh_d);
`ifdef MASKING_SHARE_REFRESH_EN
    rz_acc = '0;
    for (int i = 0; i < NSHARES - 1; i++) begin
      z_sh_d[i] = z_sh_d[i] ^ rz_v[i];
      rz_acc    = rz_acc ^ rz_v[i];
    end
    z_sh_d[NSHARES-1] = z_sh_d[NSHARES-1] ^ rz_acc;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      x_sh2_q     <= '0;
      y_sh2_q     <= '0;
      z_sh_q      <= '0;
      z_out_q     <= '0;
    end else begin
      out_valid_q <= valid1_q;
      if (valid1_q) begin
        x_sh2_q <= x_sh1_q;
        y_sh2_q <= y_sh1_q;
        z_sh_q  <= z_sh_d;
        z_out_q <= z_out_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign x_shares  = x_sh2_q;
  assign y_shares  = y_sh2_q;
  assign z_shares  = z_sh_q;
  assign z_out     = z_out_q;

endmodule

// File: tb/tb_masking_core.sv
// Directed self-checking bench for masking_core (8-bit, 8 shares).
// Builds with or without MASKING_SHARE_REFRESH_EN.
module tb_masking_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  x, y;
  logic [55:0] rand_x, rand_y;
`ifdef MASKING_SHARE_REFRESH_EN
  logic [55:0] rand_z;
`endif
  logic        out_valid;
  logic [63:0] x_shares, y_shares, z_shares;
  logic [7:0]  z_out;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [55:0] rx;
    logic [55:0] ry;
  } op_t;

  masking_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .rand_x    (rand_x),
    .rand_y    (rand_y),
`ifdef MASKING_SHARE_REFRESH_EN
    .rand_z    (rand_z),
`endif
    .out_valid (out_valid),
    .x_shares  (x_shares),
    .y_shares  (y_shares),
    .z_shares  (z_shares),
    .z_out     (z_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] xv, input logic [7:0] yv,
                       input logic [55:0] rx, input logic [55:0] ry);
    in_valid = v;
    x        = xv;
    y        = yv;
    rand_x   = rx;
    rand_y   = ry;
  endtask

  function automatic logic [7:0] fold(input logic [63:0] v);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) acc = acc ^ v[8*i +: 8];
    return acc;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 56'h0, 56'h0);
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid);
    else passed++;
    checks++;
    if ({x_shares, y_shares, z_shares, z_out} !== '0)
      $display("FAIL reset_data: got %h %h %h %h expected all 0", x_shares, y_shares, z_shares, z_out);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_masks;
    drive(1'b1, 8'hAA, 8'hF0, 56'h0, 56'h0);
    tick();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL zero_early_valid: got %b expected 0", out_valid);
    else passed++;
    drive(1'b0, 8'h00, 8'h00, 56'h0, 56'h0);
    tick();
    checks++;
    if (out_valid !== 1'b1) $display("FAIL zero_valid: got %b expected 1", out_valid);
    else passed++;
    checks++;
    if (x_shares !== 64'hAA00_0000_0000_0000) $display("FAIL zero_x_shares: got %h expected %h", x_shares, 64'hAA00_0000_0000_0000);
    else passed++;
    checks++;
    if (y_shares !== 64'hF000_0000_0000_0000) $display("FAIL zero_y_shares: got %h expected %h", y_shares, 64'hF000_0000_0000_0000);
    else passed++;
    checks++;
    if (z_shares !== 64'h5A00_0000_0000_0000) $display("FAIL zero_z_shares: got %h expected %h", z_shares, 64'h5A00_0000_0000_0000);
    else passed++;
    checks++;
    if (z_out !== 8'h5A) $display("FAIL zero_z_out: got %h expected 5a", z_out);
    else passed++;
    tick();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL zero_valid_drop: got %b expected 0", out_valid);
    else passed++;
  endtask

  task automatic test_masks;
    drive(1'b1, 8'hAA, 8'hF0, 56'h01_0101_0101_0101, 56'h10_1010_1010_1010);
    tick();
    drive(1'b0, 8'h00, 8'h00, 56'h0, 56'h0);
    tick();
    checks++;
    if (out_valid !== 1'b1) $display("FAIL mask_valid: got %b expected 1", out_valid);
    else passed++;
    checks++;
    if (x_shares !== 64'hAB01_0101_0101_0101) $display("FAIL mask_x_shares: got %h expected %h", x_shares, 64'hAB01_0101_0101_0101);
    else passed++;
    checks++;
    if (y_shares !== 64'hE010_1010_1010_1010) $display("FAIL mask_y_shares: got %h expected %h", y_shares, 64'hE010_1010_1010_1010);
    else passed++;
    checks++;
    if (z_shares !== 64'h4B11_1111_1111_1111) $display("FAIL mask_z_shares: got %h expected %h", z_shares, 64'h4B11_1111_1111_1111);
    else passed++;
    checks++;
    if (z_out !== 8'h5A) $display("FAIL mask_z_out: got %h expected 5a", z_out);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back;
    op_t q[$];
    op_t exp;
    op_t op;
    int  n = 1000;
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        op.x  = 8'($urandom);
        op.y  = 8'($urandom);
        op.rx = {24'($urandom), 32'($urandom)};
        op.ry = {24'($urandom), 32'($urandom)};
        q.push_back(op);
        drive(1'b1, op.x, op.y, op.rx, op.ry);
      end else begin
        drive(1'b0, 8'h00, 8'h00, 56'h0, 56'h0);
      end
      tick();
      checks++;
      if (out_valid !== (i >= 1 && i <= n)) $display("FAIL b2b_valid[%0d]: got %b expected %b", i, out_valid, (i >= 1 && i <= n));
      else passed++;
      if (i >= 1 && i <= n) begin
        exp = q.pop_front();
        checks++;
        if (fold(x_shares) !== exp.x) $display("FAIL b2b_x[%0d]: got %h expected %h", i, fold(x_shares), exp.x);
        else passed++;
        checks++;
        if (fold(y_shares) !== exp.y) $display("FAIL b2b_y[%0d]: got %h expected %h", i, fold(y_shares), exp.y);
        else passed++;
        checks++;
        if ({x_shares[55:0], y_shares[55:0]} !== {exp.rx, exp.ry})
          $display("FAIL b2b_masks[%0d]: got %h %h expected %h %h", i, x_shares[55:0], y_shares[55:0], exp.rx, exp.ry);
        else passed++;
        checks++;
        if (z_out !== (exp.x ^ exp.y)) $display("FAIL b2b_z_out[%0d]: got %h expected %h", i, z_out, exp.x ^ exp.y);
        else passed++;
        checks++;
        if (fold(z_shares) !== (exp.x ^ exp.y)) $display("FAIL b2b_z_fold[%0d]: got %h expected %h", i, fold(z_shares), exp.x ^ exp.y);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_in_flight;
    drive(1'b1, 8'h12, 8'h34, 56'h0, 56'h0);
    tick();
    drive(1'b1, 8'h56, 8'h78, 56'h0, 56'h0);
    tick();
    rst = 1'b1;
    drive(1'b1, 8'h9A, 8'hBC, 56'h0, 56'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 56'h0, 56'h0);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL rif_valid: got %b expected 0", out_valid);
    else passed++;
    checks++;
    if ({x_shares, y_shares, z_shares, z_out} !== '0)
      $display("FAIL rif_data: got %h %h %h %h expected all 0", x_shares, y_shares, z_shares, z_out);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || z_out !== 8'h00)
        $display("FAIL rif_stale[%0d]: got valid %b z %h expected 0 00", i, out_valid, z_out);
      else passed++;
    end
  endtask

  task automatic test_hold;
    drive(1'b1, 8'h3C, 8'h0F, 56'h22_2222_2222_2222, 56'h0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 56'h0, 56'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 8'(i * 37 + 5), 8'(i * 11 + 9), {7{8'(i + 1)}}, {7{8'(i + 2)}});
      tick();
      checks++;
      if (out_valid !== 1'b0) $display("FAIL hold_valid[%0d]: got %b expected 0", i, out_valid);
      else passed++;
      checks++;
      if ({x_shares, y_shares, z_shares, z_out} !==
          {64'h1E22_2222_2222_2222, 64'h0F00_0000_0000_0000, 64'h1122_2222_2222_2222, 8'h33})
        $display("FAIL hold_data[%0d]: got %h %h %h %h expected 1e22222222222222 0f00000000000000 1122222222222222 33",
                 i, x_shares, y_shares, z_shares, z_out);
      else passed++;
    end
  endtask

`ifdef MASKING_SHARE_REFRESH_EN
  task automatic test_refresh;
    rand_z = {7{8'hFF}};
    drive(1'b1, 8'hAA, 8'hF0, 56'h01_0101_0101_0101, 56'h10_1010_1010_1010);
    tick();
    drive(1'b0, 8'h00, 8'h00, 56'h0, 56'h0);
    tick();
    rand_z = 56'h0;
    checks++;
    if (z_shares !== 64'hB4EE_EEEE_EEEE_EEEE) $display("FAIL refresh_z_shares: got %h expected %h", z_shares, 64'hB4EE_EEEE_EEEE_EEEE);
    else passed++;
    checks++;
    if (z_out !== 8'h5A) $display("FAIL refresh_z_out: got %h expected 5a", z_out);
    else passed++;
    tick();
  endtask
`endif

  initial begin
`ifdef MASKING_SHARE_REFRESH_EN
    rand_z = 56'h0;
`endif
    test_reset();
    test_zero_masks();
    test_masks();
    test_back_to_back();
    test_reset_in_flight();
    test_hold();
`ifdef MASKING_SHARE_REFRESH_EN
    test_refresh();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
